// File: rtl/dw_weight_row_loader.sv
// Kernel-row weight loader: streams one row, BPEB-encodes each weight into a shadow
// bank and swaps it into the active bank. Optional feature macro: DW_WLOAD_ZERO_ROW_SKIP_EN.
module dw_weight_row_loader #(
  parameter int unsigned num_pe_col        = 4,
  parameter int unsigned nb_taps           = 11,
  parameter int unsigned weight_width      = 16,
  parameter int unsigned weight_bpr_width  = ((weight_width + 1) / 2) * 3,
  parameter int unsigned ETC_width         = 4,
  parameter int unsigned width_current_tap = (nb_taps > 8) ? 4 : 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [width_current_tap-1:0]                         cfg_kernel_size,
  input  logic [3:0]                                           cfg_n_ap,
  input  logic                                                 cfg_broadcast,
  input  logic                                                 w_valid,
  output logic                                                 w_ready,
  input  logic [weight_width-1:0]                              w_data,
  input  logic                                                 w_last,
  input  logic                                                 swap,
  output logic                                                 row_ready,
  output logic [num_pe_col-1:0][weight_width*nb_taps-1:0]      WRegs,
  output logic [num_pe_col-1:0][weight_bpr_width*nb_taps-1:0]  WBPRs,
  output logic [num_pe_col-1:0][ETC_width*nb_taps-1:0]         WETCs,
  output logic [num_pe_col-1:0]                                row_zero,
  output logic                                                 zero_row_skip,
  output logic                                                 err_len,
  input  logic                                                 err_clr
);

  localparam int unsigned NG = (weight_width + 1) / 2;
  localparam int unsigned CW = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;
  localparam int unsigned TW = width_current_tap;

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_FULL} state_e;

  // Group i covers {w[2i+1], w[2i], w[2i-1]}; ext carries w[-1]=0 and the sign bit on top.
  function automatic logic [weight_bpr_width-1:0] bpeb_bits(input logic [weight_width-1:0] w,
                                                             input logic [3:0] n_ap);
    logic [2*NG:0]                 ext;
    logic [weight_bpr_width-1:0]   b;
    ext = '0;
    ext[weight_width:1] = w;
    ext[2*NG] = w[weight_width-1];
    b = '0;
    for (int unsigned i = 0; i < NG; i++) begin
      if (i >= {28'd0, n_ap}) b[3*i +: 3] = ext[2*i +: 3];
    end
    return b;
  endfunction

  function automatic logic [ETC_width-1:0] etc_count(input logic [weight_bpr_width-1:0] b);
    logic [ETC_width-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NG; i++) begin
      if (b[3*i +: 3] != 3'b000 && b[3*i +: 3] != 3'b111) n = n + ETC_width'(1);
    end
    return n;
  endfunction

  state_e                    state_q;
  logic [TW-1:0]             tap_cnt_q, tap_cnt_d;
  logic [CW-1:0]             col_cnt_q, col_cnt_d;
  logic [TW-1:0]             k_q, k_eff;
  logic [3:0]                nap_q, nap_eff;
  logic                      bc_q, bc_eff;
  logic                      first_beat, tap_wrap, is_last, accept, err_len_d;

  logic                      enc_vld_q;
  logic [weight_width-1:0]   enc_w_q;
  logic [TW-1:0]             enc_tap_q;
  logic [CW-1:0]             enc_col_q;
  logic                      enc_bc_q;
  logic [3:0]                enc_nap_q;
  logic [weight_bpr_width-1:0] enc_bpr;
  logic [ETC_width-1:0]      enc_etc;

  logic [num_pe_col-1:0][weight_width*nb_taps-1:0]     sh_w_q;
  logic [num_pe_col-1:0][weight_bpr_width*nb_taps-1:0] sh_b_q;
  logic [num_pe_col-1:0][ETC_width*nb_taps-1:0]        sh_e_q;
  logic [num_pe_col-1:0]     sh_zero;
  logic                      do_swap, do_skip;

  always_comb begin
    first_beat = (tap_cnt_q == '0) && (col_cnt_q == '0);
    k_eff      = first_beat ? cfg_kernel_size : k_q;
    nap_eff    = first_beat ? cfg_n_ap        : nap_q;
    bc_eff     = first_beat ? cfg_broadcast   : bc_q;
    tap_wrap   = (tap_cnt_q == k_eff - TW'(1));
    is_last    = tap_wrap && (bc_eff || col_cnt_q == CW'(num_pe_col - 1));
    accept     = w_valid && w_ready;
    tap_cnt_d  = tap_cnt_q;
    col_cnt_d  = col_cnt_q;
    if (accept) begin
      if (is_last) begin
        tap_cnt_d = '0;
        col_cnt_d = '0;
      end else if (tap_wrap) begin
        tap_cnt_d = '0;
        col_cnt_d = col_cnt_q + CW'(1);
      end else begin
        tap_cnt_d = tap_cnt_q + TW'(1);
      end
    end
    // w_last is only checked against the count, never used to steer it.
    err_len_d = err_len;
    if (err_clr) err_len_d = 1'b0;
    else if (accept && (w_last != is_last)) err_len_d = 1'b1;
  end

  always_comb begin
    enc_bpr = bpeb_bits(enc_w_q, enc_nap_q);
    enc_etc = etc_count(enc_bpr);
    for (int unsigned c = 0; c < num_pe_col; c++) sh_zero[c] = ~|sh_e_q[c];
  end

  assign do_swap = (state_q == S_FULL) && swap;

`ifdef DW_WLOAD_ZERO_ROW_SKIP_EN
  // The final beat is still in the encode stage, so fold its ETC into the zero test.
  assign do_skip = (state_q == S_DRAIN) && (&sh_zero) && (enc_etc == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_row_skip <= 1'b0;
    else     zero_row_skip <= do_skip;
  end
`else
  assign do_skip       = 1'b0;
  assign zero_row_skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FILL;
      w_ready   <= 1'b1;
      row_ready <= 1'b0;
      tap_cnt_q <= '0;
      col_cnt_q <= '0;
      k_q       <= '0;
      nap_q     <= '0;
      bc_q      <= 1'b0;
      enc_vld_q <= 1'b0;
      enc_w_q   <= '0;
      enc_tap_q <= '0;
      enc_col_q <= '0;
      enc_bc_q  <= 1'b0;
      enc_nap_q <= '0;
      err_len   <= 1'b0;
    end else begin
      tap_cnt_q <= tap_cnt_d;
      col_cnt_q <= col_cnt_d;
      err_len   <= err_len_d;
      enc_vld_q <= accept;
      if (accept) begin
        enc_w_q   <= w_data;
        enc_tap_q <= tap_cnt_q;
        enc_col_q <= col_cnt_q;
        enc_bc_q  <= bc_eff;
        enc_nap_q <= nap_eff;
        if (first_beat) begin
          k_q   <= cfg_kernel_size;
          nap_q <= cfg_n_ap;
          bc_q  <= cfg_broadcast;
        end
      end
      unique case (state_q)
        S_FILL: begin
          if (accept && is_last) begin
            state_q <= S_DRAIN;
            w_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (do_skip) begin
            state_q <= S_FILL;
            w_ready <= 1'b1;
          end else begin
            state_q   <= S_FULL;
            row_ready <= 1'b1;
          end
        end
        S_FULL: begin
          if (swap) begin
            state_q   <= S_FILL;
            row_ready <= 1'b0;
            w_ready   <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_FILL;
          w_ready   <= 1'b1;
          row_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_w_q   <= '0;
      sh_b_q   <= '0;
      sh_e_q   <= '0;
      WRegs    <= '0;
      WBPRs    <= '0;
      WETCs    <= '0;
      row_zero <= '0;
    end else if (do_swap) begin
      WRegs    <= sh_w_q;
      WBPRs    <= sh_b_q;
      WETCs    <= sh_e_q;
      row_zero <= sh_zero;
      sh_w_q   <= '0;
      sh_b_q   <= '0;
      sh_e_q   <= '0;
    end else if (do_skip) begin
      sh_w_q <= '0;
      sh_b_q <= '0;
      sh_e_q <= '0;
    end else if (enc_vld_q) begin
      for (int unsigned c = 0; c < num_pe_col; c++) begin
        for (int unsigned t = 0; t < nb_taps; t++) begin
          if ((enc_bc_q || enc_col_q == CW'(c)) && enc_tap_q == TW'(t)) begin
            sh_w_q[c][t*weight_width     +: weight_width]     <= enc_w_q;
            sh_b_q[c][t*weight_bpr_width +: weight_bpr_width] <= enc_bpr;
            sh_e_q[c][t*ETC_width        +: ETC_width]        <= enc_etc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dw_weight_row_loader.sv
// Self-checking bench for dw_weight_row_loader: directed scenarios plus randomized rows
// compared against an array-based model of the shadow and active banks.
module tb_dw_weight_row_loader;

  localparam int NC = 4;
  localparam int NT = 11;
  localparam int WW = 16;
  localparam int BW = 24;
  localparam int EW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [TW-1:0] cfg_kernel_size;
  logic [3:0]    cfg_n_ap;
  logic          cfg_broadcast;
  logic          w_valid, w_ready, w_last, swap, row_ready, zero_row_skip, err_len, err_clr;
  logic [WW-1:0] w_data;
  logic [NC-1:0][WW*NT-1:0] WRegs;
  logic [NC-1:0][BW*NT-1:0] WBPRs;
  logic [NC-1:0][EW*NT-1:0] WETCs;
  logic [NC-1:0]            row_zero;

  dw_weight_row_loader #(
    .num_pe_col(NC), .nb_taps(NT), .weight_width(WW), .ETC_width(EW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_kernel_size(cfg_kernel_size), .cfg_n_ap(cfg_n_ap),
    .cfg_broadcast(cfg_broadcast), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last), .swap(swap), .row_ready(row_ready), .WRegs(WRegs), .WBPRs(WBPRs),
    .WETCs(WETCs), .row_zero(row_zero), .zero_row_skip(zero_row_skip), .err_len(err_len),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned sh_w [NC][NT];
  int unsigned sh_b [NC][NT];
  int unsigned sh_e [NC][NT];
  int unsigned act_w[NC][NT];
  int unsigned act_b[NC][NT];
  int unsigned act_e[NC][NT];
  logic [NC-1:0] exp_rz;
  bit exp_err;
  bit last_skipped;
  int unsigned wq[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Group i of the encoding is bits 2i+1..2i-1 of the weight, i.e. bits 2i+2..2i of 2*w.
  function automatic int unsigned m_group(input int unsigned w, input int unsigned nap,
                                          input int unsigned i);
    if (i < nap) return 0;
    return ((w * 2) >> (2 * i)) & 7;
  endfunction

  function automatic int unsigned m_bpr(input int unsigned w, input int unsigned nap);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 8; i++) r += m_group(w, nap, i) << (3 * i);
    return r;
  endfunction

  function automatic int unsigned m_etc(input int unsigned w, input int unsigned nap);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      int unsigned g = m_group(w, nap, i);
      if (g != 0 && g != 7) r++;
    end
    return r;
  endfunction

  function automatic logic [511:0] pack_col(input int unsigned a[NT], input int fw);
    logic [511:0] v = '0;
    for (int t = 0; t < NT; t++) v = v | (512'(a[t]) << (t * fw));
    return v;
  endfunction

  function automatic bit model_all_zero();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++)
        if (sh_e[c][t] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_shadow();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) begin
        sh_w[c][t] = 0; sh_b[c][t] = 0; sh_e[c][t] = 0;
      end
  endtask

  task automatic model_reset();
    clear_shadow();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) begin
        act_w[c][t] = 0; act_b[c][t] = 0; act_e[c][t] = 0;
      end
    exp_rz  = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_beat(input int unsigned w, input int unsigned col, input int unsigned tap,
                            input bit bc, input int unsigned nap);
    for (int unsigned c = 0; c < NC; c++) begin
      if (bc || c == col) begin
        sh_w[c][tap] = w;
        sh_b[c][tap] = m_bpr(w, nap);
        sh_e[c][tap] = m_etc(w, nap);
      end
    end
  endtask

  task automatic check_bank(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk({tag, "_WRegs"}, 512'(WRegs[c]), pack_col(act_w[c], WW));
      chk({tag, "_WBPRs"}, 512'(WBPRs[c]), pack_col(act_b[c], BW));
      chk({tag, "_WETCs"}, 512'(WETCs[c]), pack_col(act_e[c], EW));
    end
    chk({tag, "_row_zero"}, 512'(row_zero), 512'(exp_rz));
  endtask

  // Streams wq[0..n-1] back to back; ends at the falling edge after the final beat's drain.
  task automatic send_row(input int unsigned k, input int unsigned nap, input bit bc,
                          input int bad_idx, input bit perturb);
    int unsigned n;
    bit skip_exp;
    n = bc ? k : k * NC;
    @(negedge clk);
    cfg_kernel_size = TW'(k);
    cfg_n_ap        = 4'(nap);
    cfg_broadcast   = bc;
    for (int unsigned b = 0; b < n; b++) begin
      if (b > 0) @(negedge clk);
      if (perturb && b == 1) begin
        cfg_kernel_size = TW'($urandom_range(1, NT));
        cfg_n_ap        = 4'($urandom_range(0, 15));
        cfg_broadcast   = 1'($urandom_range(0, 1));
      end
      chk("w_ready_fill", 512'(w_ready), 512'(1'b1));
      w_valid = 1'b1;
      w_data  = WW'(wq[b]);
      w_last  = (b == n - 1) ^ (int'(b) == bad_idx);
      model_beat(wq[b], bc ? 0 : b / k, b % k, bc, nap);
      @(posedge clk);
    end
    if (bad_idx >= 0 && bad_idx < int'(n)) exp_err = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("drain_row_ready", 512'(row_ready), 512'(1'b0));
    chk("drain_w_ready", 512'(w_ready), 512'(1'b0));
    @(negedge clk);
    skip_exp = 1'b0;
`ifdef DW_WLOAD_ZERO_ROW_SKIP_EN
    skip_exp = model_all_zero();
`endif
    chk("row_ready", 512'(row_ready), 512'(!skip_exp));
    chk("w_ready_after", 512'(w_ready), 512'(skip_exp));
    chk("zero_row_skip", 512'(zero_row_skip), 512'(skip_exp));
    chk("err_len", 512'(err_len), 512'(exp_err));
    if (skip_exp) clear_shadow();
    last_skipped = skip_exp;
  endtask

  task automatic do_swap(input string tag);
    bit rz;
    swap    = 1'b1;
    w_valid = 1'b1;
    w_data  = WW'($urandom);
    w_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    swap    = 1'b0;
    w_valid = 1'b0;
    for (int c = 0; c < NC; c++) begin
      rz = 1'b1;
      for (int t = 0; t < NT; t++) begin
        act_w[c][t] = sh_w[c][t];
        act_b[c][t] = sh_b[c][t];
        act_e[c][t] = sh_e[c][t];
        if (sh_e[c][t] != 0) rz = 1'b0;
      end
      exp_rz[c] = rz;
    end
    clear_shadow();
    chk({tag, "_row_ready"}, 512'(row_ready), 512'(1'b0));
    chk({tag, "_w_ready"}, 512'(w_ready), 512'(1'b1));
    check_bank(tag);
  endtask

  initial begin
    int unsigned k, nap, n;
    bit bc;
    int bad;
    rst = 1'b1; cfg_kernel_size = TW'(1); cfg_n_ap = '0; cfg_broadcast = 1'b0;
    w_valid = 1'b0; w_data = '0; w_last = 1'b0; swap = 1'b0; err_clr = 1'b0;
    last_skipped = 1'b0;
    model_reset();
    #12;
    chk("rst_w_ready", 512'(w_ready), 512'(1'b1));
    chk("rst_row_ready", 512'(row_ready), 512'(1'b0));
    chk("rst_err_len", 512'(err_len), 512'(1'b0));
    chk("rst_skip", 512'(zero_row_skip), 512'(1'b0));
    check_bank("rst");
    @(negedge clk);
    rst = 1'b0;

    // Broadcast K=3, n_ap=0, weights 1,2,3
    wq = '{1, 2, 3};
    send_row(3, 0, 1'b1, -1, 1'b0);
    do_swap("bc3");
    for (int c = 0; c < NC; c++) chk("bc3_etc_const", 512'(WETCs[c][11:0]), 512'(12'h221));
    chk("bc3_bpr_tap0", 512'(WBPRs[0][23:0]), 512'(24'h000002));
    chk("bc3_bpr_hi", 512'(WBPRs[2][BW*NT-1:BW*3]), 512'(0));
    chk("bc3_rz_const", 512'(row_zero), 512'(4'b0000));

    // Swap outside FULL is ignored
    @(negedge clk);
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    chk("swap_ign_rr", 512'(row_ready), 512'(1'b0));
    check_bank("swap_ign");

    // n_ap=1 strips the only effective term of weight 1
    wq = '{1};
    send_row(1, 1, 1'b1, -1, 1'b0);
    if (!last_skipped) do_swap("nap1");
`ifndef DW_WLOAD_ZERO_ROW_SKIP_EN
    chk("nap1_rz_const", 512'(row_zero), 512'(4'b1111));
`else
    check_bank("nap1_keep");
`endif
    @(negedge clk);
    chk("skip_one_cycle", 512'(zero_row_skip), 512'(1'b0));

    // 0xFFFF: group0=110, the rest 111
    wq = '{32'hFFFF};
    send_row(1, 0, 1'b1, -1, 1'b0);
    do_swap("ffff");
    chk("ffff_etc", 512'(WETCs[3][3:0]), 512'(4'd1));
    chk("ffff_bpr", 512'(WBPRs[0][23:0]), 512'(24'hFFFFFE));

    // Per-column K=3, values 1..12
    wq.delete();
    for (int unsigned i = 1; i <= 12; i++) wq.push_back(i);
    send_row(3, 0, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("full_hold_w_ready", 512'(w_ready), 512'(1'b0));
    chk("full_hold_row_ready", 512'(row_ready), 512'(1'b1));
    do_swap("percol");
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < 3; t++)
        chk("percol_const", 512'(WRegs[c][t*WW +: WW]), 512'(3 * c + t + 1));

    // w_last early on beat 2 of 3
    wq = '{7, 8, 9};
    send_row(3, 0, 1'b1, 1, 1'b0);
    do_swap("errlen");
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", 512'(err_len), 512'(1'b0));

    // Reset after 2 of 3 beats
    @(negedge clk);
    cfg_kernel_size = TW'(3); cfg_n_ap = '0; cfg_broadcast = 1'b1;
    w_valid = 1'b1; w_data = 16'h0005; w_last = 1'b0;
    @(negedge clk);
    w_data = 16'h0006;
    @(negedge clk);
    w_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_w_ready", 512'(w_ready), 512'(1'b1));
    chk("mid_rst_row_ready", 512'(row_ready), 512'(1'b0));
    check_bank("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wq = '{16'h0010, 16'h0020, 16'h0030};
    send_row(3, 0, 1'b1, -1, 1'b0);
    do_swap("post_rst");

    // Randomized rows with config churn mid-row
    for (int r = 0; r < 25; r++) begin
      k   = $urandom_range(1, NT);
      nap = $urandom_range(0, 9);
      bc  = 1'($urandom_range(0, 1));
      n   = bc ? k : k * NC;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      wq.delete();
      for (int unsigned i = 0; i < n; i++)
        wq.push_back(($urandom_range(0, 3) == 0) ? 0 : ($urandom & 32'hFFFF));
      send_row(k, nap, bc, bad, 1'($urandom_range(0, 1)));
      if (!last_skipped) do_swap("rand");
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk("rand_err_clr", 512'(err_len), 512'(1'b0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dw_weight_row_loader.md
# dw_weight_row_loader

Synthesisable, parametrised successor to the behavioural kernel-row weight loading and BPEB encoding for the depthwise-conv PE array.
- Accepts one kernel row of weights over a valid/ready stream.
- BPEB-encodes each weight against `n_ap` and counts its effective terms (ETC).
- Assembles the row in a shadow bank, then swaps it into the active `WRegs`/`WBPRs`/`WETCs` bank that feeds the array columns.
- Adds broadcast or per-column weights, runtime kernel size, length checking and zero-row detection.

## Interface
Parameters:
- `num_pe_col`, 4, PE array columns.
- `nb_taps`, 11, taps per column (max kernel size).
- `weight_width`, 16, weight bits.
- `weight_bpr_width`, ((weight_width+1)/2)*3, encoded bits per weight (3 per 2-bit group).
- `ETC_width`, 4, ETC field width; must hold (weight_width+1)/2.
- `width_current_tap`, nb_taps > 8 ? 4 : 3, kernel-size/tap index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_kernel_size`  in  width_current_tap  taps per row, 1..nb_taps.
- `cfg_n_ap`  in  4  number of abandoned low groups.
- `cfg_broadcast`  in  1  1: one row is written to all columns; 0: distinct row per column.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  loader accepts beat.
- `w_data`  in  weight_width  weight.
- `w_last`  in  1  final beat of row (checked only).
- `swap`  in  1  request shadow→active transfer.
- `row_ready`  out  1  shadow holds a complete row.
- `WRegs`  out  [num_pe_col][weight_width*nb_taps]  active weights.
- `WBPRs`  out  [num_pe_col][weight_bpr_width*nb_taps]  active encoded weights.
- `WETCs`  out  [num_pe_col][ETC_width*nb_taps]  active ETCs.
- `row_zero`  out  num_pe_col  active column has all-zero ETC.
- `zero_row_skip`  out  1  one-cycle pulse when a row is discarded (macro only).
- `err_len`  out  1  sticky `w_last` mismatch.
- `err_clr`  in  1  clears `err_len`.

## Operation
- States:
  - FILL: `w_ready`=1.
  - DRAIN: last beat in the encode stage; `w_ready`=0.
  - FULL: `w_ready`=0, `row_ready`=1.
- Row setup: `cfg_kernel_size`, `cfg_n_ap` and `cfg_broadcast` are latched on the first beat of a row. Later config changes do not affect that row.
- Beat order: column-major. Tap 0..K-1 of column 0, then column 1, and so on. Beats per row = K when broadcasting, K*num_pe_col otherwise.
- Counters: `tap_cnt` wraps at K-1. `col_cnt` increments on wrap. The last beat is `tap_cnt`=K-1 and (broadcast or `col_cnt`=num_pe_col-1).
- Encoding for group i in 0..(weight_width+1)/2-1:
  - i < n_ap: bits = 000.
  - otherwise: bits {w[2i+1], w[2i], w[2i-1]}, with w[-1]=0 and w[weight_width] = sign extension for odd widths.
  - ETC = number of groups whose bits are neither 000 nor 111.
- Taps ≥ K in the shadow are zero. The shadow is cleared on every swap and on reset.
- `err_len` is set when `w_last` is high on a non-final beat or low on the final beat. Control follows the count; `w_last` never affects it. `err_clr` has priority over a simultaneous set.
- Swap: when `swap`=1 in FULL, active ← shadow, `row_zero` ← per-column OR-reduce of ETC == 0, then the state goes to FILL. `swap` outside FULL is ignored.

## Timing
- Reset values: all bank outputs, `row_zero`, `row_ready`, `zero_row_skip` and `err_len` are 0. State is FILL, so `w_ready`=1 during and after reset.
- A beat accepted at edge n is registered in the encode stage at edge n and written to the shadow at edge n+1. Throughput is 1 beat per cycle.
- Final beat accepted at edge n: DRAIN after edge n, FULL (`row_ready`=1) after edge n+1.
- Swap sampled at edge s: new active bank and `row_zero` are visible after edge s. `row_ready`=0 and `w_ready`=1 after edge s. A beat presented in the swap cycle is not accepted.
- Reset mid-row: partial row discarded, active bank zeroed.

## Configuration
- `DW_WLOAD_ZERO_ROW_SKIP_EN` defined: a completed row whose ETCs are zero for every column and tap is discarded. After edge n+1 the state goes to FILL (not FULL), the shadow is cleared, `zero_row_skip` pulses for one cycle, and the active bank is unchanged.
- Not defined: `zero_row_skip` is tied to 0, and zero rows reach FULL and swap normally.

## Test plan
- Broadcast, K=3, n_ap=0, weights 0x0001, 0x0002, 0x0003, then swap → every column has WETCs taps 1, 2, 2, WBPRs tap0 = 0x000002, taps 3..10 = 0, `row_zero`=0.
- n_ap=1, broadcast K=1, weight 0x0001 → ETC 0, `row_zero`=4'b1111. With the macro defined, `zero_row_skip` pulses, `row_ready` stays 0 and the active bank is unchanged.
- Weight 0xFFFF, n_ap=0 → ETC 1 (group0 = 110, groups 1..7 = 111).
- Per-column K=3, 12 beats of values 1..12 → column c tap t = 3c+t+1. `row_ready` rises two cycles after the 12th beat. `w_ready` is 0 until swap.
- `w_last` asserted on beat 2 of 3 → `err_len`=1, row still completes after 3 beats. `err_clr` returns `err_len` to 0.
- Reset asserted after 2 of 3 beats → outputs 0 and `w_ready`=1. A fresh 3-beat row then completes normally.
